// File: rtl/batcharger_pkg.sv
// Shared types and constants for the battery-charger measurement scheduler.
// Channel numbering, FSM state encoding and a round-robin step helper.
package batcharger_pkg;

  localparam int NCH  = 3;
  localparam int CH_V = 0;
  localparam int CH_I = 1;
  localparam int CH_T = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CONV
  } state_t;

  // Channel that follows ch in V, I, T order, wrapping T back to V.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'(CH_T)) ? 2'(CH_V) : ch + 2'd1;
  endfunction

endpackage

// File: rtl/batcharger_rr_arb.sv
// Round-robin picker over the three measurement channels.
// Returns the first pending channel at or after the pointer.
module batcharger_rr_arb
  import batcharger_pkg::*;
(
  input  logic [NCH-1:0] pending,
  input  logic [1:0]     ptr,
  output logic [NCH-1:0] grant,
  output logic [1:0]     idx
);

  logic       found;
  logic [1:0] cand;

  // Walk V, I, T starting at the pointer; first pending channel wins.
  always_comb begin
    grant = '0;
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!found && pending[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
      cand = next_ch(cand);
    end
  end

endmodule

// File: rtl/batcharger_meas_sched.sv
// Schedules the shared SAR ADC across battery V, I and T channels.
// Periodic and on-demand requests, round-robin service, timeout flags.
module batcharger_meas_sched
  import batcharger_pkg::*;
#(
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] req,
  input  logic       vtok,
  input  logic [7:0] vbat,
  input  logic [7:0] ibat,
  input  logic [7:0] tbat,
  output logic       vmeasen,
  output logic       imeasen,
  output logic       tmeasen,
  output logic [7:0] vbat_q,
  output logic [7:0] ibat_q,
  output logic [7:0] tbat_q,
  output logic [2:0] valid,
  output logic [2:0] err,
  output logic       busy
);

  state_t     state, state_n;
  logic [15:0] pcnt;
  logic        tick;
  logic [2:0]  pending;
  logic [1:0]  ptr;
  logic [1:0]  sel;
  logic [2:0]  sel_oh;
  logic [7:0]  tcnt;
  logic [2:0]  gnt;
  logic [1:0]  gidx;
  logic        done;
  logic        tmo;
  logic [2:0]  clr;

  batcharger_rr_arb u_arb (
    .pending (pending),
    .ptr     (ptr),
    .grant   (gnt),
    .idx     (gidx)
  );

  assign tick   = en && (pcnt == 16'(PERIOD - 1));
  assign sel_oh = 3'b001 << sel;
  assign done   = (state == CONV) && en && vtok;
  assign tmo    = (state == CONV) && en && !vtok
                  && (tcnt == 8'(TIMEOUT - 1));
  assign clr    = (done || tmo) ? sel_oh : 3'b000;
  assign busy   = (state == GRANT) || (state == CONV);

  // Sweep timer: free-runs while enabled, held at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en)
      pcnt <= '0;
    else if (tick)
      pcnt <= '0;
    else
      pcnt <= pcnt + 16'd1;
  end

  // Request merge; a fresh set beats the completion clear.
  always_ff @(posedge clk) begin
    if (rst || !en)
      pending <= '0;
    else
      pending <= (pending & ~clr) | req | {3{tick}};
  end

  // Next-state logic; dropping en always returns to IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (|pending) state_n = GRANT;
      GRANT: state_n = CONV;
      CONV:  if (done || tmo) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!en)
      state_n = IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Channel selection is frozen when leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst)
      sel <= 2'(CH_V);
    else if (state == IDLE && state_n == GRANT)
      sel <= gidx;
  end

  // Round-robin pointer moves past the channel just finished.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 2'(CH_V);
    else if (done || tmo)
      ptr <= next_ch(sel);
  end

  // Conversion age counter, zero on every CONV entry.
  always_ff @(posedge clk) begin
    if (rst || state != CONV)
      tcnt <= '0;
    else
      tcnt <= tcnt + 8'd1;
  end

  // Registered one-hot ADC enables, high for every CONV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      {tmeasen, imeasen, vmeasen} <= 3'b000;
    end else if (state_n == CONV) begin
      {tmeasen, imeasen, vmeasen} <= sel_oh;
    end else begin
      {tmeasen, imeasen, vmeasen} <= 3'b000;
    end
  end

  // Result capture on the end-of-conversion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vbat_q <= '0;
      ibat_q <= '0;
      tbat_q <= '0;
    end else if (done) begin
      unique case (sel)
        2'(CH_V): vbat_q <= vbat;
        2'(CH_I): ibat_q <= ibat;
        2'(CH_T): tbat_q <= tbat;
        default: ;
      endcase
    end
  end

  // New-result strobe, one cycle per completed conversion.
  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else
      valid <= done ? sel_oh : 3'b000;
  end

  // Sticky timeout flags, cleared by a good conversion.
  always_ff @(posedge clk) begin
    if (rst)
      err <= '0;
    else if (done)
      err <= err & ~sel_oh;
    else if (tmo)
      err <= err | sel_oh;
  end

endmodule
